reduceron_io_arbiter: RTL

- Shares one peripheral IO bus between two requesters: the Reduceron core IO port (15-bit address, 15-bit data, read and write strobes) and a host debug port.
- Sequences each transfer with an ack handshake and a timeout, and stalls the core while its access is pending.
- Latches the core's final result when the core asserts finish.
- Sits between the Reduceron instance and the board/testbench peripherals.

---
 rtl/reduceron_io_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reduceron_io_arbiter.sv
// reduceron_io_arbiter: round-robin sharing of one IO bus between the Reduceron core and a host debug port
// Each transfer waits for bus_ack or a timeout; the core's finish result is latched once.
module reduceron_io_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              core_iowrite,
  input  logic              core_ioread,
  input  logic [ADDR_W-1:0] core_ioaddr,
  input  logic [DATA_W-1:0] core_iowd,
  output logic [DATA_W-1:0] core_iord,
  output logic              core_stall,
  input  logic              core_finish,
  input  logic [17:0]       core_result,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wd,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              bus_re,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wd,
  input  logic [DATA_W-1:0] bus_rd,
  input  logic              bus_ack,
  output logic              res_valid,
  output logic [14:0]       res_value,
  output logic [2:0]        res_tag,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, CORE_XFER, HOST_XFER} state_t;
  state_t state_q, state_d;
  logic prio_host_q, prio_host_d;
  logic [15:0] cnt_q, cnt_d;
  logic re_q, re_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d, iord_q, iord_d, hrd_q, hrd_d;
  logic done_q, done_d, err_q, err_d;
  logic rv_q, rv_d;
  logic [14:0] rval_q, rval_d;
  logic [2:0] rtag_q, rtag_d;
  logic core_req, host_ok, idle, in_xfer, tmo, fin, grant_core, grant_host, core_fin;
  logic [DATA_W-1:0] fin_data;
  // the host keeps host_req high during its done pulse, so that cycle must not re-grant it
  assign core_req   = core_iowrite | core_ioread;
  assign host_ok    = host_req & ~done_q;
  assign idle       = state_q == IDLE;
  assign in_xfer    = ~idle;
  assign tmo        = in_xfer & ~bus_ack & (cnt_q == 16'(TIMEOUT - 1));
  assign fin        = in_xfer & (bus_ack | tmo);
  assign fin_data   = bus_ack ? bus_rd : '0;
  assign core_fin   = (state_q == CORE_XFER) & fin;
  assign grant_core = idle & core_req & (~host_ok | ~prio_host_q);
  assign grant_host = idle & host_ok & (~core_req | prio_host_q);
  assign core_stall = core_req & ~core_fin;
  assign core_iord  = core_fin ? fin_data : iord_q;
  assign host_done  = done_q;
  assign host_rdata = hrd_q;
  assign bus_re     = re_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wd     = wd_q;
  assign res_valid  = rv_q;
  assign res_value  = rval_q;
  assign res_tag    = rtag_q;
  assign err_timeout = err_q;
  always_comb begin
    state_d     = state_q;
    prio_host_d = prio_host_q;
    cnt_d       = in_xfer ? cnt_q + 16'd1 : cnt_q;
    re_d        = re_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    if (grant_core) begin
      state_d     = CORE_XFER;
      prio_host_d = 1'b1;
      cnt_d       = '0;
      we_d        = core_iowrite;
      re_d        = ~core_iowrite;
      addr_d      = core_ioaddr;
      wd_d        = core_iowd;
    end else if (grant_host) begin
      state_d     = HOST_XFER;
      prio_host_d = 1'b0;
      cnt_d       = '0;
      we_d        = host_we;
      re_d        = ~host_we;
      addr_d      = host_addr;
      wd_d        = host_wd;
    end else if (fin) begin
      state_d = IDLE;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end
    iord_d = core_fin ? fin_data : iord_q;
    done_d = (state_q == HOST_XFER) & fin;
    hrd_d  = done_d ? fin_data : hrd_q;
    err_d  = err_q | tmo;
    rv_d   = rv_q | core_finish;
    rval_d = (core_finish & ~rv_q) ? core_result[17:3] : rval_q;
    rtag_d = (core_finish & ~rv_q) ? core_result[2:0] : rtag_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_host_q <= 1'b0;
      cnt_q       <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      iord_q      <= '0;
      done_q      <= 1'b0;
      hrd_q       <= '0;
      err_q       <= 1'b0;
      rv_q        <= 1'b0;
      rval_q      <= '0;
      rtag_q      <= '0;
    end else begin
      state_q     <= state_d;
      prio_host_q <= prio_host_d;
      cnt_q       <= cnt_d;
      re_q        <= re_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      iord_q      <= iord_d;
      done_q      <= done_d;
      hrd_q       <= hrd_d;
      err_q       <= err_d;
      rv_q        <= rv_d;
      rval_q      <= rval_d;
      rtag_q      <= rtag_d;
    end
  end
endmodule
